gray_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one Gray-code counter between two requesters. Each requester asks for a burst of N counter steps; the block grants one requester at a time, steps the counter once per cycle for N cycles, reports per-burst completion and wrap-around, then returns to idle. It sits between requester logic and the counter, which it owns as a sub-module.

---
 rtl/gray_arbiter_pkg.sv | 20 ++
 rtl/gray_step_ctr.sv | 40 ++++
 rtl/gray_arbiter.sv | 127 ++++++++++++
 tb/tb_gray_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gray_arbiter_pkg.sv
// Shared types and defaults for the two-requester Gray-counter arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gray_arbiter_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Owner index (0/1) to one-hot grant/done vector.
  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gray_step_ctr.sv
// Binary step counter with Gray-coded output and a wrap indication.
// Latency: Value updates on the Clk edge that samples Clr or Step.
// Backpressure: none; Step is obeyed every cycle it is high.
//
// Ports:
//   Clk, Reset (async, active low)
//   Clr   : synchronous clear of the binary count (wins over Step)
//   Step  : advance the count by one, modulo 2^WIDTH
//   Value : Gray encoding of the current count
//   Wrap  : combinational, high when the Step sampled at the next edge
//           takes the count from all-ones back to zero
module gray_step_ctr
  import gray_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clr,
  input  logic             Step,
  output logic [WIDTH-1:0] Value,
  output logic             Wrap
);

  logic [WIDTH-1:0] bin;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bin <= '0;
    end else if (Clr) begin
      bin <= '0;
    end else if (Step) begin
      bin <= bin + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign Wrap  = Step & ~Clr & (&bin);
  assign Value = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_arbiter.sv
// Round-robin arbiter sequencing fixed-length bursts on one shared Gray counter.
// Latency: grant one cycle after the IDLE request edge; burst of L costs L+2 cycles.
// Backpressure: requests are only sampled in IDLE; a held Req simply waits.
//
// Ports:
//   Clk, Reset (async, active low)
//   Req[1:0]      : burst requests, sampled in IDLE only
//   Len0, Len1    : burst lengths, captured at grant
//   Clr           : counter clear, honoured in IDLE only
//   Gnt[1:0]      : one-hot owner during RUN and DONE
//   Busy          : state != IDLE
//   Done[1:0]     : one-cycle completion pulse for the owner
//   Wrapped       : with Done, set if the burst wrapped the counter
//   Value         : Gray-coded counter value
module gray_arbiter
  import gray_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Req,
  input  logic [LEN_W-1:0] Len0,
  input  logic [LEN_W-1:0] Len1,
  input  logic             Clr,
  output logic [1:0]       Gnt,
  output logic             Busy,
  output logic [1:0]       Done,
  output logic             Wrapped,
  output logic [WIDTH-1:0] Value
);

  state_t           state, state_n;
  logic             owner, owner_n;
  logic             pri, pri_n;
  logic [LEN_W-1:0] remaining, remaining_n;
  logic             wrap_flag, wrap_flag_n;

  logic             sel;
  logic [LEN_W-1:0] sel_len;
  logic             ctr_step;
  logic             ctr_clr;
  logic             ctr_wrap;

  gray_step_ctr #(
    .WIDTH(WIDTH)
  ) u_ctr (
    .Clk  (Clk),
    .Reset(Reset),
    .Clr  (ctr_clr),
    .Step (ctr_step),
    .Value(Value),
    .Wrap (ctr_wrap)
  );

  // A lone request wins outright; a tie goes to the priority holder.
  always_comb begin
    sel = Req[1];
    if (Req == 2'b11) begin
      sel = pri;
    end
    sel_len = sel ? Len1 : Len0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      pri       <= 1'b0;
      remaining <= '0;
      wrap_flag <= 1'b0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      pri       <= pri_n;
      remaining <= remaining_n;
      wrap_flag <= wrap_flag_n;
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    pri_n       = pri;
    remaining_n = remaining;
    wrap_flag_n = wrap_flag;
    ctr_step    = 1'b0;
    ctr_clr     = 1'b0;
    case (state)
      IDLE: begin
        // Clear and grant may coincide: the burst then steps from zero.
        ctr_clr = Clr;
        if (|Req) begin
          owner_n     = sel;
          remaining_n = sel_len;
          wrap_flag_n = 1'b0;
          pri_n       = ~sel;
          state_n     = (sel_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        ctr_step    = 1'b1;
        remaining_n = remaining - LEN_W'(1);
        if (ctr_wrap) begin
          wrap_flag_n = 1'b1;
        end
        if (remaining == LEN_W'(1)) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Outputs decode registered state only; Req never reaches them directly.
  assign Busy    = (state != IDLE);
  assign Gnt     = Busy ? owner_onehot(owner) : 2'b00;
  assign Done    = (state == DONE) ? owner_onehot(owner) : 2'b00;
  assign Wrapped = (state == DONE) & wrap_flag;

endmodule

// File: tb/tb_gray_arbiter.sv
module tb_gray_arbiter;

  logic       Clk;
  logic       Reset;
  logic [1:0] Req;
  logic [3:0] Len0;
  logic [3:0] Len1;
  logic       Clr;
  logic [1:0] Gnt;
  logic       Busy;
  logic [1:0] Done;
  logic       Wrapped;
  logic [2:0] Value;

  int tests = 0;
  int fails = 0;

  gray_arbiter #(
    .WIDTH(3),
    .LEN_W(4)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Req    (Req),
    .Len0   (Len0),
    .Len1   (Len1),
    .Clr    (Clr),
    .Gnt    (Gnt),
    .Busy   (Busy),
    .Done   (Done),
    .Wrapped(Wrapped),
    .Value  (Value)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One row per clock cycle: inputs driven for that cycle, outputs expected
  // during that cycle (before the edge that ends it).
  typedef struct packed {
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic       clr;
    logic [1:0] gnt;
    logic       busy;
    logic [1:0] done;
    logic       wr;
    logic [2:0] val;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] req, input logic [3:0] l0, input logic [3:0] l1,
                     input logic clr, input logic [1:0] gnt, input logic busy,
                     input logic [1:0] done, input logic wr, input logic [2:0] val);
    vec_t v;
    v.req = req; v.len0 = l0; v.len1 = l1; v.clr = clr;
    v.gnt = gnt; v.busy = busy; v.done = done; v.wr = wr; v.val = val;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [1:0] gnt, input logic busy,
                            input logic [1:0] done, input logic wr, input logic [2:0] val);
    check({tag, " Gnt"}, 32'(Gnt), 32'(gnt));
    check({tag, " Busy"}, 32'(Busy), 32'(busy));
    check({tag, " Done"}, 32'(Done), 32'(done));
    check({tag, " Wrapped"}, 32'(Wrapped), 32'(wr));
    check({tag, " Value"}, 32'(Value), 32'(val));
  endtask

  function automatic logic [2:0] gray(input int b);
    logic [2:0] x;
    x = b[2:0];
    return x ^ (x >> 1);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [1:0] exp_g;

    Reset = 1'b0; Req = 2'b00; Len0 = 4'd0; Len1 = 4'd0; Clr = 1'b0;
    #12;
    check_outs("reset", 2'b00, 1'b0, 2'b00, 1'b0, 3'b000);

    //   req    len0  len1  clr   gnt   busy  done   wr    val
    add(2'b01, 4'd5, 4'd0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000); // 0 grant r0, L=5
    add(2'b00, 4'd7, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b000); // Req drop, Len change ignored
    add(2'b00, 4'd7, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b001);
    add(2'b00, 4'd7, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b011);
    add(2'b00, 4'd7, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b010);
    add(2'b00, 4'd7, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b110);
    add(2'b00, 4'd0, 4'd0, 1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 3'b111); // 6 DONE, no wrap
    add(2'b10, 4'd0, 4'd4, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b111); // 7 grant r1, L=4
    add(2'b00, 4'd0, 4'd4, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 3'b111);
    add(2'b00, 4'd0, 4'd4, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 3'b101);
    add(2'b00, 4'd0, 4'd4, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 3'b100);
    add(2'b00, 4'd0, 4'd4, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0, 3'b000);
    add(2'b00, 4'd0, 4'd0, 1'b0, 2'b10, 1'b1, 2'b10, 1'b1, 3'b001); // 12 DONE, wrapped
    add(2'b01, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b001); // 13 grant r0, L=0
    add(2'b00, 4'd0, 4'd0, 1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 3'b001); // 14 straight to DONE
    add(2'b01, 4'd4, 4'd0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b001); // 15 grant r0, L=4
    add(2'b00, 4'd4, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b001);
    add(2'b00, 4'd4, 4'd0, 1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 3'b011); // Clr in RUN ignored
    add(2'b00, 4'd4, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b010);
    add(2'b00, 4'd4, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b110);
    add(2'b00, 4'd0, 4'd0, 1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 3'b111); // 20 Clr in DONE ignored
    add(2'b01, 4'd2, 4'd0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 3'b111); // 21 Clr + grant
    add(2'b00, 4'd2, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b000);
    add(2'b00, 4'd2, 4'd0, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 3'b001);
    add(2'b00, 4'd0, 4'd0, 1'b0, 2'b01, 1'b1, 2'b01, 1'b0, 3'b011); // 24 DONE
    add(2'b00, 4'd0, 4'd0, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 3'b011); // 25 Clr alone in IDLE
    add(2'b00, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000);

    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge Clk);
      Req = vecs[i].req; Len0 = vecs[i].len0; Len1 = vecs[i].len1; Clr = vecs[i].clr;
      check_outs($sformatf("v%0d", i), vecs[i].gnt, vecs[i].busy, vecs[i].done,
                 vecs[i].wr, vecs[i].val);
    end

    // Both requesters held with L=2: alternating grants, L+2 cycles per burst.
    @(negedge Clk);
    Req = 2'b00; Clr = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1; Req = 2'b11; Len0 = 4'd2; Len1 = 4'd2;
    cnt = 0;
    for (int b = 0; b < 3; b++) begin
      exp_g = (b % 2 == 1) ? 2'b10 : 2'b01;
      check_outs($sformatf("rr%0d idle", b), 2'b00, 1'b0, 2'b00, 1'b0, gray(cnt));
      @(negedge Clk);
      for (int r = 0; r < 2; r++) begin
        check_outs($sformatf("rr%0d run%0d", b, r), exp_g, 1'b1, 2'b00, 1'b0, gray(cnt));
        @(negedge Clk);
        cnt++;
      end
      if (b == 2) Req = 2'b00;
      check_outs($sformatf("rr%0d done", b), exp_g, 1'b1, exp_g, 1'b0, gray(cnt));
      @(negedge Clk);
    end
    check("rr final Value", 32'(Value), 32'(3'b101));
    check("rr final Busy", 32'(Busy), 32'(1'b0));

    // Reset asserted mid-RUN with three steps left.
    Req = 2'b01; Len0 = 4'd5;
    @(negedge Clk);
    Req = 2'b00;
    @(negedge Clk);
    @(negedge Clk);
    check("midrun Gnt", 32'(Gnt), 32'(2'b01));
    #2;
    Reset = 1'b0;
    #1;
    check_outs("async reset", 2'b00, 1'b0, 2'b00, 1'b0, 3'b000);
    @(negedge Clk);
    check_outs("reset held", 2'b00, 1'b0, 2'b00, 1'b0, 3'b000);
    Reset = 1'b1; Req = 2'b11; Len0 = 4'd1; Len1 = 4'd1;
    @(negedge Clk);
    check("post-reset Gnt", 32'(Gnt), 32'(2'b01));
    check("post-reset Busy", 32'(Busy), 32'(1'b1));
    @(negedge Clk);
    check_outs("post-reset done", 2'b01, 1'b1, 2'b01, 1'b0, 3'b001);
    @(negedge Clk);
    check("post-reset rearb idle Busy", 32'(Busy), 32'(1'b0));
    @(negedge Clk);
    Req = 2'b00;
    check("post-reset second Gnt", 32'(Gnt), 32'(2'b10));
    @(negedge Clk);
    check_outs("post-reset second done", 2'b10, 1'b1, 2'b10, 1'b0, 3'b011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
